// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module  : uart_rx_deserializer
// Brief   : UART receive path; mid-bit sampling of start/data/parity/stop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx_enable,
    input  logic              i_rx_in,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sync;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_armed;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;

    logic w_rx_s;
    logic w_cnt_clr;
    logic w_idx_clr;
    logic w_shift_en;
    logic w_par_ld;
    logic w_done;

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_par_ld    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_enable && r_armed && !w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (r_bit_cnt == c_HALF) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_idx_clr   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (r_bit_cnt == c_FULL) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (r_bit_cnt == c_FULL) begin
                    w_cnt_clr   = 1'b1;
                    w_par_ld    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_bit_cnt == c_FULL) begin
                    w_cnt_clr   = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sync    <= 2'b11;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_armed   <= 1'b1;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= {r_sync[0], i_rx_in};

            if (w_cnt_clr || r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
            end

            if (w_par_ld) begin
                r_par <= w_rx_s ^ (^r_shift);
            end

            // A low stop bit (break) disarms until the line is seen high again.
            if (w_done && !w_rx_s) begin
                r_armed <= 1'b0;
            end else if (r_state == S_IDLE && w_rx_s) begin
                r_armed <= 1'b1;
            end

            r_valid <= w_done;
            if (w_done) begin
                r_data <= r_shift;
                r_perr <= PARITY_EN & r_par;
                r_ferr <= ~w_rx_s;
            end
        end
    end

    assign o_rx_data    = r_data;
    assign o_rx_valid   = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
